// File: rtl/issue_queue_entry_allocator_if.sv
// Dispatch/release handshake bundle for the issue-queue entry allocator.
// master: dispatch/wakeup side driving requests; slave: the allocator.
interface issue_queue_entry_allocator_if #(
  parameter int ENTRY_NUM      = 16,
  parameter int DISPATCH_WIDTH = 2,
  parameter int RELEASE_WIDTH  = 4
);
  localparam int IW = $clog2(ENTRY_NUM);

  logic [DISPATCH_WIDTH-1:0]    allocReq;
  logic [DISPATCH_WIDTH*IW-1:0] allocPtr;
  logic                         allocatable;
  logic [RELEASE_WIDTH-1:0]     releaseEntry;
  logic [RELEASE_WIDTH*IW-1:0]  releasePtr;
  logic                         flush;
  logic [IW:0]                  freeCount;
  logic                         allocError;

  modport master (
    output allocReq, releaseEntry, releasePtr, flush,
    input  allocPtr, allocatable, freeCount, allocError
  );

  modport slave (
    input  allocReq, releaseEntry, releasePtr, flush,
    output allocPtr, allocatable, freeCount, allocError
  );
endinterface

// File: rtl/issue_queue_entry_allocator.sv
// Issue-queue entry allocator: circular free list of entry indices.
// Dispatch pops packed lanes from head (combinational pointers, all-or-nothing),
// wakeup releases push at tail, flush refills the list, overflow is sticky.
// Optional build macro ISSUE_QUEUE_ALLOC_CHECK_EN adds a busy vector that
// rejects releases of non-busy entries and same-cycle duplicate releases.
module issue_queue_entry_allocator #(
  parameter int ENTRY_NUM      = 16,
  parameter int DISPATCH_WIDTH = 2,
  parameter int RELEASE_WIDTH  = 4
)(
  input  logic clk,
  input  logic rst,
  issue_queue_entry_allocator_if.slave bus
);
  localparam int IW = $clog2(ENTRY_NUM);
  localparam int CW = IW + 1;

  logic [ENTRY_NUM-1:0][IW-1:0]      fl_q;
  logic [IW-1:0]                     head_q, tail_q;
  logic [CW-1:0]                     count_q;
  logic                              err_q;

  logic [DISPATCH_WIDTH-1:0][IW-1:0] alloc_ofs, alloc_idx;
  logic [CW-1:0]                     n_req, n_eff;
  logic                              can_alloc;

  logic [RELEASE_WIDTH-1:0][IW-1:0]  rel_ptr, rel_ofs;
  logic [RELEASE_WIDTH-1:0]          rel_ok, rel_acc;
  logic [CW-1:0]                     r_cnt, room;
  logic                              ovf, chk_err;

  // Prefix count of requesting lanes: holes in allocReq consume no entries.
  always_comb begin
    n_req = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      alloc_ofs[i] = n_req[IW-1:0];
      n_req        = n_req + CW'(bus.allocReq[i]);
    end
  end

  assign can_alloc = (n_req <= count_q);
  assign n_eff     = can_alloc ? n_req : '0;

  for (genvar i = 0; i < DISPATCH_WIDTH; i++) begin : g_alloc
    assign alloc_idx[i]                = fl_q[head_q + alloc_ofs[i]];
    assign bus.allocPtr[i*IW +: IW]    = alloc_idx[i];
  end

  for (genvar j = 0; j < RELEASE_WIDTH; j++) begin : g_rel
    assign rel_ptr[j] = bus.releasePtr[j*IW +: IW];
  end

`ifdef ISSUE_QUEUE_ALLOC_CHECK_EN
  logic [ENTRY_NUM-1:0] busy_q, busy_n;

  // Reject releases of idle entries and repeats of a lower lane's index.
  always_comb begin
    rel_ok  = bus.releaseEntry;
    chk_err = 1'b0;
    for (int j = 0; j < RELEASE_WIDTH; j++) begin
      if (!busy_q[rel_ptr[j]]) rel_ok[j] = 1'b0;
      for (int l = 0; l < j; l++)
        if (bus.releaseEntry[l] && (rel_ptr[l] == rel_ptr[j])) rel_ok[j] = 1'b0;
      if (bus.releaseEntry[j] && !rel_ok[j]) chk_err = 1'b1;
    end
  end

  // Busy tracking: accepted releases clear, granted allocations set.
  always_comb begin
    busy_n = busy_q;
    for (int j = 0; j < RELEASE_WIDTH; j++)
      if (rel_acc[j]) busy_n[rel_ptr[j]] = 1'b0;
    for (int i = 0; i < DISPATCH_WIDTH; i++)
      if (bus.allocReq[i] && can_alloc) busy_n[alloc_idx[i]] = 1'b1;
  end

  // Busy vector register; cleared by reset and flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          busy_q <= '0;
    else if (bus.flush) busy_q <= '0;
    else               busy_q <= busy_n;
  end
`else
  assign rel_ok  = bus.releaseEntry;
  assign chk_err = 1'b0;
`endif

  // Room left after this cycle's grant; releases beyond it are dropped,
  // lowest lanes keep priority.
  assign room = CW'(ENTRY_NUM) - count_q + n_eff;

  // Pack accepted releases onto consecutive tail slots.
  always_comb begin
    r_cnt   = '0;
    ovf     = 1'b0;
    rel_acc = '0;
    rel_ofs = '0;
    for (int j = 0; j < RELEASE_WIDTH; j++) begin
      rel_ofs[j] = r_cnt[IW-1:0];
      if (rel_ok[j]) begin
        if (r_cnt < room) begin
          rel_acc[j] = 1'b1;
          r_cnt      = r_cnt + CW'(1);
        end else begin
          ovf = 1'b1;
        end
      end
    end
  end

  // Free-list state; flush outranks alloc/release and keeps the error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < ENTRY_NUM; k++) fl_q[k] <= IW'(k);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CW'(ENTRY_NUM);
      err_q   <= 1'b0;
    end else if (bus.flush) begin
      for (int k = 0; k < ENTRY_NUM; k++) fl_q[k] <= IW'(k);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CW'(ENTRY_NUM);
    end else begin
      for (int j = 0; j < RELEASE_WIDTH; j++)
        if (rel_acc[j]) fl_q[tail_q + rel_ofs[j]] <= rel_ptr[j];
      head_q  <= head_q + n_eff[IW-1:0];
      tail_q  <= tail_q + r_cnt[IW-1:0];
      count_q <= count_q - n_eff + r_cnt;
      if (ovf || chk_err) err_q <= 1'b1;
    end
  end

  assign bus.allocatable = can_alloc;
  assign bus.freeCount   = count_q;
  assign bus.allocError  = err_q;
endmodule

// File: tb/tb_issue_queue_entry_allocator.sv
// Bench for issue_queue_entry_allocator: queue-based free-list model,
// per-cycle compare on the falling edge, directed pins then random traffic.
module tb_issue_queue_entry_allocator;
  localparam int N  = 16;
  localparam int DW = 2;
  localparam int RW = 4;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  issue_queue_entry_allocator_if #(.ENTRY_NUM(N), .DISPATCH_WIDTH(DW), .RELEASE_WIDTH(RW)) ifc ();

  issue_queue_entry_allocator #(.ENTRY_NUM(N), .DISPATCH_WIDTH(DW), .RELEASE_WIDTH(RW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: free entries in allocation order, sticky error.
  int q[$];
  int gnt[$];
  int out[$];
  bit merr;
  bit mbusy [N];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_init(input bit clr_err);
    q.delete();
    gnt.delete();
    for (int k = 0; k < N; k++) begin
      q.push_back(k);
      mbusy[k] = 1'b0;
    end
    if (clr_err) merr = 1'b0;
  endfunction

  function automatic void model_step();
    int n;
    int p;
    bit ok;
    gnt.delete();
    if (!rst) begin m_init(1'b1); return; end
    if (ifc.flush) begin m_init(1'b0); return; end
    n = $countones(ifc.allocReq);
    if (n <= q.size())
      for (int i = 0; i < n; i++) gnt.push_back(q.pop_front());
    for (int j = 0; j < RW; j++) begin
      if (ifc.releaseEntry[j]) begin
        p  = int'(ifc.releasePtr[j*IW +: IW]);
        ok = 1'b1;
`ifdef ISSUE_QUEUE_ALLOC_CHECK_EN
        if (!mbusy[p]) ok = 1'b0;
        for (int l = 0; l < j; l++)
          if (ifc.releaseEntry[l] && int'(ifc.releasePtr[l*IW +: IW]) == p) ok = 1'b0;
        if (!ok) merr = 1'b1;
`endif
        if (ok) begin
          if (q.size() < N) begin
            q.push_back(p);
            mbusy[p] = 1'b0;
          end else begin
            merr = 1'b1;
          end
        end
      end
    end
    foreach (gnt[i]) mbusy[gnt[i]] = 1'b1;
  endfunction

  // Every cycle: status outputs and the pointer of every requesting lane.
  always @(negedge clk) begin
    int k;
    check("allocatable", int'(ifc.allocatable), int'($countones(ifc.allocReq) <= q.size()));
    check("freeCount", int'(ifc.freeCount), q.size());
    check("allocError", int'(ifc.allocError), int'(merr));
    k = 0;
    for (int i = 0; i < DW; i++) begin
      if (ifc.allocReq[i]) begin
        if (k < q.size()) check("allocPtr", int'(ifc.allocPtr[i*IW +: IW]), q[k]);
        k++;
      end
    end
  end

  task automatic drive(input logic [DW-1:0] ar, input logic [RW-1:0] re,
                       input logic [RW*IW-1:0] rp, input logic fl);
    ifc.allocReq     = ar;
    ifc.releaseEntry = re;
    ifc.releasePtr   = rp;
    ifc.flush        = fl;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic tick();
    bit fl;
    bit rs;
    @(posedge clk); #1;
    fl = ifc.flush;
    rs = rst;
    model_step();
    if (!rs || fl) out.delete();
    else foreach (gnt[i]) out.push_back(gnt[i]);
  endtask

  task automatic drive_rand(input bit bogus);
    logic [DW-1:0]    ar;
    logic [RW-1:0]    re;
    logic [RW*IW-1:0] rp;
    int idx;
    ar = DW'($urandom);
    re = '0;
    rp = '0;
    for (int j = 0; j < RW; j++) begin
      if (bogus && $urandom_range(0, 7) == 0) begin
        re[j] = 1'b1;
        rp[j*IW +: IW] = IW'($urandom_range(0, N-1));
      end else if (out.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, out.size()-1);
        re[j] = 1'b1;
        rp[j*IW +: IW] = IW'(out[idx]);
        out.delete(idx);
      end
    end
    drive(ar, re, rp, ($urandom_range(0, 49) == 0));
  endtask

  initial begin
    drive('0, '0, '0, 1'b0);
    m_init(1'b1);
    tick();
    tick();
    rst = 1'b1;

    // Two-lane grant straight out of reset.
    drive(2'b11, '0, '0, 1'b0);
    settle();
    check("rst_ptr0", int'(ifc.allocPtr[0 +: IW]), 0);
    check("rst_ptr1", int'(ifc.allocPtr[IW +: IW]), 1);
    check("rst_allocatable", int'(ifc.allocatable), 1);
    check("rst_free", int'(ifc.freeCount), 16);
    check("rst_err", int'(ifc.allocError), 0);
    tick();

    // Hole on lane 0: lane 1 takes the next entry.
    drive(2'b10, '0, '0, 1'b0);
    settle();
    check("free_14", int'(ifc.freeCount), 14);
    check("hole_ptr1", int'(ifc.allocPtr[IW +: IW]), 2);
    tick();

    drive(2'b11, '0, '0, 1'b0);
    settle();
    check("free_13", int'(ifc.freeCount), 13);
    repeat (6) tick();

    // One free entry left: two-lane request stalls, single lane granted.
    settle();
    check("near_empty_stall", int'(ifc.allocatable), 0);
    check("near_empty_free", int'(ifc.freeCount), 1);
    tick();
    drive(2'b01, '0, '0, 1'b0);
    settle();
    check("last_grant", int'(ifc.allocatable), 1);
    check("last_ptr0", int'(ifc.allocPtr[0 +: IW]), 15);
    tick();

    // Empty list with simultaneous release: no bypass.
    drive(2'b01, 4'b0101, {4'd0, 4'd3, 4'd0, 4'd5}, 1'b0);
    settle();
    check("empty_free", int'(ifc.freeCount), 0);
    check("empty_stall", int'(ifc.allocatable), 0);
    tick();
    drive(2'b11, '0, '0, 1'b0);
    settle();
    check("refill_free", int'(ifc.freeCount), 2);
    check("refill_ptr0", int'(ifc.allocPtr[0 +: IW]), 5);
    check("refill_ptr1", int'(ifc.allocPtr[IW +: IW]), 3);

    // Flush beats a same-cycle release and allocation.
    drive(2'b11, 4'b0001, 16'd0, 1'b1);
    tick();
    drive(2'b11, '0, '0, 1'b0);
    settle();
    check("flush_free", int'(ifc.freeCount), 16);
    check("flush_ptr0", int'(ifc.allocPtr[0 +: IW]), 0);
    check("flush_ptr1", int'(ifc.allocPtr[IW +: IW]), 1);
    check("flush_err", int'(ifc.allocError), 0);

    // Releasing into a full list raises the sticky error.
    drive('0, 4'b0001, 16'd7, 1'b0);
    tick();
    drive('0, '0, '0, 1'b0);
    settle();
    check("bad_rel_err", int'(ifc.allocError), 1);
    check("bad_rel_free", int'(ifc.freeCount), 16);
    drive('0, '0, '0, 1'b1);
    tick();
    drive('0, '0, '0, 1'b0);
    settle();
    check("err_sticky_flush", int'(ifc.allocError), 1);

    // Asynchronous reset mid-cycle clears the error.
    @(posedge clk); #2;
    rst = 1'b0;
    m_init(1'b1);
    out.delete();
    #1;
    check("async_rst_err", int'(ifc.allocError), 0);
    check("async_rst_free", int'(ifc.freeCount), 16);
    tick();
    rst = 1'b1;

    // Legal random traffic, then traffic with stray releases.
    repeat (1500) begin
      drive_rand(1'b0);
      tick();
    end
    check("legal_traffic_err", int'(ifc.allocError), 0);
    repeat (500) begin
      drive_rand(1'b1);
      tick();
    end
    drive('0, '0, '0, 1'b0);
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
